regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the multicycle RISC-V datapath.
- Successor to the fixed 32x32, 2R/1W register block. Adds:
  - a configurable data width and depth,
  - a second write port with defined collision priority,
  - a hardware clear sequencer that zeroes the whole array after reset or on request, with a ready handshake.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero: reads return 0 and writes are discarded.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr_req  input  1  single-cycle request to re-zero the whole array.
- ready  output  1  high when the array is valid and accepting writes.
- rdAddr1  input  ADDR_W  read port 1 address.
- rdAddr2  input  ADDR_W  read port 2 address.
- rdData1  output  DATA_W  read port 1 data, combinational.
- rdData2  output  DATA_W  read port 2 data, combinational.
- wrEn0  input  1  write port 0 enable.
- wrAddr0  input  ADDR_W  write port 0 address.
- wrData0  input  DATA_W  write port 0 data.
- wrEn1  input  1  write port 1 enable.
- wrAddr1  input  ADDR_W  write port 1 address.
- wrData1  input  DATA_W  write port 1 data.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- FSM states are CLEAR and READY, with a clear index idx of ADDR_W bits.
- Reset:
  - rst high at an edge sets state=CLEAR, idx=0, ready=0.
  - rst has priority over every other input.
  - rst asserted mid-clear restarts idx at 0.
- CLEAR state:
  - Each edge writes 0 to entry idx, then idx <= idx+1.
  - At the edge that clears entry DEPTH-1, state goes to READY and idx wraps to 0.
  - ready therefore rises exactly DEPTH edges after the first edge with rst low (32 for defaults).
  - User writes are ignored.
  - clr_req is ignored.
  - rdData1/rdData2 are forced to 0.
- READY state:
  - ready=1.
  - clr_req=1 at an edge moves to CLEAR with idx=0. Any write presented in that same cycle is dropped; ready falls after that edge.
- Writes (READY only, clr_req low):
  - Each port with wrEn high updates its entry at the edge.
  - wrAddr0 == wrAddr1 with both enabled: port 1 wins; port 0 data is discarded.
  - With ZERO_REG=1, writes to address 0 have no effect.
- Reads:
  - Combinational from array contents; latency 0.
  - A same-cycle write is not visible until after the edge (see optional feature).
  - Address 0 returns 0 when ZERO_REG=1.
- Widths:
  - Data is stored as-is.
  - No sign handling; no partial writes.
- Outputs during rst: ready=0, rdData1=rdData2=0.
- Array contents are undefined only until the clear sequence completes; there is no initial-file preload.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined:
  - Each read port compares its address against the enabled write ports in READY state.
  - On a match it returns the write data in the same cycle, giving write-to-read forwarding.
  - Priority follows the collision rule: a port 1 match beats a port 0 match.
  - A pending write dropped by clr_req is not forwarded.
  - With ZERO_REG=1, address 0 is never bypassed.
- Undefined: reads return stored contents only, so the new value is visible the cycle after the write edge.

Test Plan:
- Reset for 2 cycles then release:
  - ready=0 for 32 cycles, then 1.
  - Reading every address returns 0x00000000.
- READY, write 0xDEADBEEF to x5 via port 0 and 0x12345678 to x9 via port 1 in the same cycle:
  - The next cycle reads rdData1(x5)=0xDEADBEEF and rdData2(x9)=0x12345678.
- Both ports write x7: port 0 with 0x1111, port 1 with 0x2222 -> x7 reads 0x2222.
- Write 0xFFFFFFFF to x0 (ZERO_REG=1) -> x0 reads 0.
- Write x3=0xAA, then pulse clr_req with a simultaneous write x4=0xBB:
  - ready drops for 32 cycles.
  - Afterwards x3=0 and x4=0.
- Same-cycle write/read of x10=0x55:
  - Reads the old value (0) without REGFILE_WR_BYPASS_EN.
  - Reads 0x55 with it defined.
  - Also assert rst at idx=17 mid-clear -> ready is delayed a full 32 cycles from release.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback and the multi-port register file:
// read addresses/data, two write ports, clear request and ready.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              clr_req;
  logic              ready;
  logic [ADDR_W-1:0] rdAddr1;
  logic [ADDR_W-1:0] rdAddr2;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;
  logic              wrEn0;
  logic [ADDR_W-1:0] wrAddr0;
  logic [DATA_W-1:0] wrData0;
  logic              wrEn1;
  logic [ADDR_W-1:0] wrAddr1;
  logic [DATA_W-1:0] wrData1;

  modport master (
    output clr_req, rdAddr1, rdAddr2,
    output wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1,
    input  ready, rdData1, rdData2
  );

  modport slave (
    input  clr_req, rdAddr1, rdAddr2,
    input  wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1,
    output ready, rdData1, rdData2
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised 2R/2W register file with hardware clear sequencer and ready handshake.
// Optional same-cycle write-to-read forwarding when REGFILE_WR_BYPASS_EN is defined.
//
// state | meaning
// CLEAR | zeroing entry idx each edge; reads return 0, writes and clr_req ignored
// READY | array valid, writes accepted, clr_req restarts the clear sequence
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              ready_int;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      CLEAR: begin
        idx_nxt = idx + ADDR_W'(1);
        if (&idx) state_nxt = READY;
      end
      READY: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  // Port 0 yields to port 1 on an address collision.
  always_comb begin
    accept = (state == READY) && !bus.clr_req && !rst;
    wr1_ok = accept && bus.wrEn1 && !is_zero_addr(bus.wrAddr1);
    wr0_ok = accept && bus.wrEn0 && !is_zero_addr(bus.wrAddr0) &&
             !(bus.wrEn1 && (bus.wrAddr1 == bus.wrAddr0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[idx] <= '0;
      end else begin
        if (wr0_ok) mem[bus.wrAddr0] <= bus.wrData0;
        if (wr1_ok) mem[bus.wrAddr1] <= bus.wrData1;
      end
    end
  end

  assign ready_int = (state == READY) && !rst;
  assign bus.ready = ready_int;

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if (ready_int && !is_zero_addr(a)) begin
`ifdef REGFILE_WR_BYPASS_EN
      if (wr1_ok && (bus.wrAddr1 == a))      d = bus.wrData1;
      else if (wr0_ok && (bus.wrAddr0 == a)) d = bus.wrData0;
      else                                   d = mem[a];
`else
      d = mem[a];
`endif
    end
    return d;
  endfunction

  always_comb begin
    bus.rdData1 = read_port(bus.rdAddr1);
    bus.rdData2 = read_port(bus.rdAddr2);
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// checked against a behavioural array model.
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents, validity flag and remaining clear edges.
  logic [31:0] m_mem [DEPTH];
  bit          m_ready;
  int          m_left;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [31:0] exp_rd(input int a);
    logic [31:0] v;
    v = 32'h0;
    if (!rst && m_ready && a != 0) begin
      v = m_mem[a];
      if (BYPASS && !bus.clr_req) begin
        if (bus.wrEn0 && int'(bus.wrAddr0) == a) v = bus.wrData0;
        if (bus.wrEn1 && int'(bus.wrAddr1) == a) v = bus.wrData1;
      end
    end
    return v;
  endfunction

  // Advance one edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b0;
      m_left  = DEPTH;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      end
    end else if (bus.clr_req) begin
      m_ready = 1'b0;
      m_left  = DEPTH;
    end else begin
      if (bus.wrEn0 && bus.wrAddr0 != 0) m_mem[bus.wrAddr0] = bus.wrData0;
      if (bus.wrEn1 && bus.wrAddr1 != 0) m_mem[bus.wrAddr1] = bus.wrData1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr_req = 1'b0;
    bus.wrEn0   = 1'b0;
    bus.wrEn1   = 1'b0;
    bus.wrAddr0 = '0;
    bus.wrAddr1 = '0;
    bus.wrData0 = '0;
    bus.wrData1 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.rdAddr1 = 5'd1;
    bus.rdAddr2 = 5'd2;
    tick();
    tick();
    n_tests++;
    if (bus.ready !== 1'b0 || bus.rdData1 !== 32'h0) begin
      $display("FAIL reset_outputs: ready=%b rdData1=%h, required ready=0 rdData1=0", bus.ready, bus.rdData1);
      n_fail++;
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      n_tests++;
      if (bus.ready !== 1'b0) begin
        $display("FAIL reset_clear_ready: cycle %0d ready=%b, required 0", i, bus.ready);
        n_fail++;
      end
      tick();
    end
    #2;
    n_tests++;
    if (bus.ready !== 1'b1) begin
      $display("FAIL reset_ready_rise: ready=%b, required 1", bus.ready);
      n_fail++;
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus.rdAddr1 = 5'(a);
      bus.rdAddr2 = 5'(DEPTH - 1 - a);
      #2;
      n_tests++;
      if (bus.rdData1 !== 32'h0 || bus.rdData2 !== 32'h0) begin
        $display("FAIL reset_contents: addr %0d rd1=%h rd2=%h, required 0", a, bus.rdData1, bus.rdData2);
        n_fail++;
      end
      tick();
    end
  endtask

  task automatic test_dual_write();
    bus.wrEn0 = 1'b1; bus.wrAddr0 = 5'd5; bus.wrData0 = 32'hDEADBEEF;
    bus.wrEn1 = 1'b1; bus.wrAddr1 = 5'd9; bus.wrData1 = 32'h12345678;
    bus.rdAddr1 = 5'd5;
    bus.rdAddr2 = 5'd9;
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (bus.rdData1 !== 32'hDEADBEEF || bus.rdData2 !== 32'h12345678) begin
      $display("FAIL dual_write: rd1=%h rd2=%h, required deadbeef 12345678", bus.rdData1, bus.rdData2);
      n_fail++;
    end
  endtask

  task automatic test_collision();
    bus.wrEn0 = 1'b1; bus.wrAddr0 = 5'd7; bus.wrData0 = 32'h1111;
    bus.wrEn1 = 1'b1; bus.wrAddr1 = 5'd7; bus.wrData1 = 32'h2222;
    bus.rdAddr1 = 5'd7;
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (bus.rdData1 !== 32'h2222) begin
      $display("FAIL collision: x7=%h, required 00002222", bus.rdData1);
      n_fail++;
    end
  endtask

  task automatic test_zero_reg();
    bus.wrEn0 = 1'b1; bus.wrAddr0 = 5'd0; bus.wrData0 = 32'hFFFFFFFF;
    bus.rdAddr1 = 5'd0;
    #2;
    n_tests++;
    if (bus.rdData1 !== 32'h0) begin
      $display("FAIL zero_reg_bypass: x0=%h, required 0", bus.rdData1);
      n_fail++;
    end
    tick();
    idle_inputs();
    bus.wrEn1 = 1'b1; bus.wrAddr1 = 5'd0; bus.wrData1 = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (bus.rdData1 !== 32'h0) begin
      $display("FAIL zero_reg: x0=%h, required 0", bus.rdData1);
      n_fail++;
    end
  endtask

  task automatic test_clear_req();
    bus.wrEn0 = 1'b1; bus.wrAddr0 = 5'd3; bus.wrData0 = 32'hAA;
    tick();
    idle_inputs();
    bus.rdAddr1 = 5'd3;
    bus.rdAddr2 = 5'd4;
    #2;
    n_tests++;
    if (bus.rdData1 !== 32'hAA) begin
      $display("FAIL clear_pre_write: x3=%h, required 000000aa", bus.rdData1);
      n_fail++;
    end
    bus.clr_req = 1'b1;
    bus.wrEn1 = 1'b1; bus.wrAddr1 = 5'd4; bus.wrData1 = 32'hBB;
    #1;
    n_tests++;
    if (bus.rdData2 !== 32'h0) begin
      $display("FAIL clear_no_forward: x4=%h, required 0", bus.rdData2);
      n_fail++;
    end
    tick();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      n_tests++;
      if (bus.ready !== 1'b0) begin
        $display("FAIL clear_ready_low: cycle %0d ready=%b, required 0", i, bus.ready);
        n_fail++;
      end
      tick();
    end
    #2;
    n_tests++;
    if (bus.ready !== 1'b1 || bus.rdData1 !== 32'h0 || bus.rdData2 !== 32'h0) begin
      $display("FAIL clear_done: ready=%b x3=%h x4=%h, required 1 0 0", bus.ready, bus.rdData1, bus.rdData2);
      n_fail++;
    end
  endtask

  task automatic test_same_cycle_read();
    bus.wrEn0 = 1'b1; bus.wrAddr0 = 5'd10; bus.wrData0 = 32'h55;
    bus.rdAddr1 = 5'd10;
    #2;
    n_tests++;
    if (bus.rdData1 !== (BYPASS ? 32'h55 : 32'h0)) begin
      $display("FAIL same_cycle_read: x10=%h, required %h", bus.rdData1, BYPASS ? 32'h55 : 32'h0);
      n_fail++;
    end
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (bus.rdData1 !== 32'h55) begin
      $display("FAIL next_cycle_read: x10=%h, required 00000055", bus.rdData1);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_clear();
    bus.clr_req = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 17; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      n_tests++;
      if (bus.ready !== 1'b0) begin
        $display("FAIL mid_clear_reset_low: cycle %0d ready=%b, required 0", i, bus.ready);
        n_fail++;
      end
      tick();
    end
    #2;
    n_tests++;
    if (bus.ready !== 1'b1) begin
      $display("FAIL mid_clear_reset_rise: ready=%b, required 1", bus.ready);
      n_fail++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.wrEn0   = 1'($urandom_range(0, 1));
      bus.wrEn1   = 1'($urandom_range(0, 1));
      bus.wrAddr0 = 5'($urandom_range(0, 7));
      bus.wrAddr1 = 5'($urandom_range(0, 7));
      bus.wrData0 = $urandom;
      bus.wrData1 = $urandom;
      bus.rdAddr1 = 5'($urandom_range(0, 7));
      bus.rdAddr2 = 5'($urandom_range(0, 31));
      bus.clr_req = ($urandom_range(0, 99) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      #2;
      n_tests++;
      if (bus.ready !== (m_ready && !rst) ||
          bus.rdData1 !== exp_rd(int'(bus.rdAddr1)) ||
          bus.rdData2 !== exp_rd(int'(bus.rdAddr2))) begin
        $display("FAIL random c=%0d: ready=%b rd1[%0d]=%h rd2[%0d]=%h, required %b %h %h",
                 c, bus.ready, bus.rdAddr1, bus.rdData1, bus.rdAddr2, bus.rdData2,
                 m_ready && !rst, exp_rd(int'(bus.rdAddr1)), exp_rd(int'(bus.rdAddr2)));
        n_fail++;
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ready = 1'b0;
    m_left  = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    test_reset();
    test_dual_write();
    test_collision();
    test_zero_reg();
    test_clear_req();
    test_same_cycle_read();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
